fir_sample_feeder: RTL and testbench
====================================

FIR_SAMPLE_FEEDER -- requirements
Module: fir_sample_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning sample FIFO depth in entries; legal values are powers of 2 from 2 to 64.
REQ-002 SHALL have parameter TIMEOUT, default 32, meaning the maximum number of cycles to wait for a filter response.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port s_data, input, 8 bits: signed upstream sample.
REQ-006 SHALL have port s_valid, input, 1 bit: upstream sample valid.
REQ-007 SHALL have port s_ready, output, 1 bit: FIFO can accept a sample.
REQ-008 SHALL have port f_data, output, 8 bits: signed sample driven to the filter data input.
REQ-009 SHALL have port f_flag, output, 1 bit: driven to the filter input_data_flag.
REQ-010 SHALL have port f_done, input, 1 bit: filter done_flag.
REQ-011 SHALL have port f_sum, input, 32 bits: signed filter sum.
REQ-012 SHALL have port r_sum, output, 32 bits: signed captured result.
REQ-013 SHALL have port r_valid, output, 1 bit: one-cycle pulse marking a new r_sum.
REQ-014 SHALL have port timeout_err, output, 1 bit: sticky filter-timeout flag.
REQ-015 SHALL have port fill, output, clog2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-016 SHALL accept a sample on a rising edge where s_valid=1 and s_ready=1.
REQ-017 SHALL drive s_ready = (fill < DEPTH), decoded from registered fill only; a simultaneous pop does not enable a push into a full FIFO.
REQ-018 SHALL wrap the FIFO read and write pointers modulo DEPTH.
REQ-019 SHALL leave fill unchanged on a simultaneous push and pop; SHALL never pop when empty.
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, SETTLE and CAPTURE.
REQ-021 SHALL transition IDLE->ISSUE when fill>0 and f_done=1, otherwise remain in IDLE.
REQ-022 SHALL, on entry to ISSUE, register the FIFO head into f_data and pop it; f_data is held until the next ISSUE.
REQ-023 SHALL assert f_flag exactly in the ISSUE cycle and deassert it in every other cycle; ISSUE always advances to WAIT_LOW.
REQ-024 SHALL transition WAIT_LOW->WAIT_HIGH when f_done=0, and WAIT_HIGH->SETTLE when f_done=1.
REQ-025 SHALL make SETTLE last exactly one cycle and then advance to CAPTURE.
REQ-026 SHALL, in CAPTURE, register r_sum<=f_sum, pulse r_valid=1 for that single cycle, and return to IDLE.
REQ-027 SHALL hold r_sum between captures.
REQ-028 SHALL clear a wait counter on entering WAIT_LOW and increment it in each WAIT_LOW or WAIT_HIGH cycle.
REQ-029 SHALL, when the wait counter reaches TIMEOUT, set timeout_err, go to IDLE and not pulse r_valid; the sample is dropped.
REQ-030 SHALL clear timeout_err only by rst.
REQ-031 SHALL give latency from acceptance into an empty FIFO in IDLE (f_done=1) to f_flag of 2 cycles.
REQ-032 SHALL keep at most one sample outstanding at the filter at any time.
REQ-033 SHALL, if f_done is already 0 while in IDLE, wait in IDLE and not issue.

Reset
REQ-034 SHALL, while rst=1, immediately force: s_ready=1; f_data=0; f_flag=0; r_sum=0; r_valid=0; timeout_err=0; fill=0; FSM in IDLE; FIFO pointers and wait counter at 0.
REQ-035 SHALL treat rst mid-transaction as discarding the in-flight sample and all FIFO contents, with no r_valid generated.
REQ-036 SHALL begin normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-037 Single sample: push 5 into the filter model (coefficients 2, 4, 8; history 1, 2) -> f_flag 2 cycles later with f_data=5; one r_valid with r_sum equal to the model sum 5*2+1*4+2*8=30.
REQ-038 Burst: push DEPTH+2 samples back-to-back -> s_ready=0 after DEPTH accepts; all samples issued in order; DEPTH+2 r_valid pulses; fill returns to 0.
REQ-039 Stuck filter: hold f_done=1 after ISSUE -> timeout_err=1 after TIMEOUT cycles; no r_valid; the next sample is still serviced.
REQ-040 Full FIFO with concurrent pop: fill=DEPTH, s_valid=1 in the pop cycle -> push refused; fill becomes DEPTH-1.
REQ-041 Reset mid-WAIT_HIGH with 3 queued samples -> all outputs at reset values; fill=0; no r_valid afterwards.
REQ-042 Negative data: push -128 -> r_sum equal to the sign-extended model sum, which is negative.

Source files
------------

// File: rtl/fir_sample_feeder.sv
// rtl/fir_sample_feeder.sv - sample FIFO feeding a handshake-driven FIR filter, one sample in flight
module fir_sample_feeder #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [7:0]         s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic signed [7:0]         f_data,
    output logic                      f_flag,
    input  logic                      f_done,
    input  logic signed [31:0]        f_sum,
    output logic signed [31:0]        r_sum,
    output logic                      r_valid,
    output logic                      timeout_err,
    output logic [$clog2(DEPTH):0]    fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        SETTLE,
        CAPTURE
    } state_t;

    state_t            state;
    logic signed [7:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     wait_cnt;
    logic [CW-1:0]     wait_cnt_inc;
    logic              push;
    logic              pop;

    // Readiness comes from the registered fill only, so a pop in the same
    // cycle never opens a slot in a full FIFO.
    assign s_ready      = (fill < FULL);
    assign push         = s_valid && s_ready;
    assign pop          = (state == IDLE) && (fill != '0) && f_done;
    assign wait_cnt_inc = wait_cnt + CW'(1);

    // Sample storage; contents are don't-care until fill says otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // FIFO pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fill <= fill + (AW + 1)'(1);
                2'b01:   fill <= fill - (AW + 1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Filter handshake: issue one sample, wait for done to drop then rise,
    // let the sum settle for a cycle, capture it; give up after TIMEOUT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            f_data      <= '0;
            f_flag      <= 1'b0;
            r_sum       <= '0;
            r_valid     <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            f_flag  <= 1'b0;
            r_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        f_data <= mem[rd_ptr];
                        f_flag <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    wait_cnt <= wait_cnt_inc;
                    if (wait_cnt_inc == TO_VAL) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else if (!f_done) begin
                        state <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    wait_cnt <= wait_cnt_inc;
                    if (wait_cnt_inc == TO_VAL) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else if (f_done) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    r_sum   <= f_sum;
                    r_valid <= 1'b1;
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb/tb_fir_sample_feeder.sv - directed self-checking bench for fir_sample_feeder
module tb_fir_sample_feeder;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 32;
    localparam int AW      = $clog2(DEPTH);

    typedef struct {
        logic signed [7:0] x;
        longint            exp;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [7:0]  s_data = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [7:0]  f_data;
    logic               f_flag;
    logic               f_done = 1'b1;
    logic signed [31:0] f_sum = '0;
    logic signed [31:0] r_sum;
    logic               r_valid;
    logic               timeout_err;
    logic [AW:0]        fill;

    fir_sample_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .f_data(f_data), .f_flag(f_flag), .f_done(f_done), .f_sum(f_sum),
        .r_sum(r_sum), .r_valid(r_valid), .timeout_err(timeout_err), .fill(fill)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Filter model: coefficients 2,4,8, history starts at 1,2 after reset.
    logic signed [7:0] h1 = 8'sd1;
    logic signed [7:0] h2 = 8'sd2;
    int busy = 0;
    int lat  = 2;
    bit stuck    = 1'b0;
    bit hold_low = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            f_done = 1'b1;
            busy   = 0;
            h1     = 8'sd1;
            h2     = 8'sd2;
            f_sum  = '0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) f_done = 1'b1;
        end else if (f_flag && !stuck) begin
            f_sum  = 2 * f_data + 4 * h1 + 8 * h2;
            h2     = h1;
            h1     = f_data;
            f_done = 1'b0;
            busy   = lat;
        end else begin
            f_done = !hold_low;
        end
    end

    // Output monitor
    int rv_count = 0;
    logic signed [31:0] rv_log[$];
    logic signed [7:0]  ff_log[$];

    always @(negedge clk) begin
        if (r_valid) begin
            rv_count++;
            rv_log.push_back(r_sum);
        end
        if (f_flag) ff_log.push_back(f_data);
    end

    task automatic run_single(input logic signed [7:0] x, input longint exp, input string tag);
        int rv0;
        int k;
        rv0     = rv_count;
        s_data  = x;
        s_valid = 1'b1;
        check({tag, " s_ready"}, s_ready, 1);
        tick();
        s_valid = 1'b0;
        check({tag, " fill after accept"}, fill, 1);
        check({tag, " f_flag early"}, f_flag, 0);
        tick();
        check({tag, " f_flag at latency 2"}, f_flag, 1);
        check({tag, " f_data"}, f_data, x);
        check({tag, " fill after pop"}, fill, 0);
        k = 0;
        while (!r_valid && k < 60) begin
            tick();
            k++;
        end
        check({tag, " r_valid seen"}, r_valid, 1);
        check({tag, " r_sum"}, r_sum, exp);
        tick();
        check({tag, " r_valid single pulse"}, r_valid, 0);
        check({tag, " r_sum held"}, r_sum, exp);
        repeat (3) tick();
        check({tag, " r_valid count"}, rv_count - rv0, 1);
    endtask

    vec_t              vecs[6];
    logic signed [7:0] bd[DEPTH + 2];
    logic signed [7:0] e1;
    logic signed [7:0] e2;
    longint            exp_v;
    logic              rdy;
    int                idx;
    int                k;
    int                rv0;
    int                ff0;

    task automatic check_reset_values(input string tag);
        check({tag, " s_ready"}, s_ready, 1);
        check({tag, " f_data"}, f_data, 0);
        check({tag, " f_flag"}, f_flag, 0);
        check({tag, " r_sum"}, r_sum, 0);
        check({tag, " r_valid"}, r_valid, 0);
        check({tag, " timeout_err"}, timeout_err, 0);
        check({tag, " fill"}, fill, 0);
    endtask

    initial begin
        vecs[0] = '{x: 8'sd5,    exp: 30};
        vecs[1] = '{x: -8'sd128, exp: -228};
        vecs[2] = '{x: 8'sd3,    exp: -466};
        vecs[3] = '{x: 8'sd127,  exp: -758};
        vecs[4] = '{x: 8'sd0,    exp: 532};
        vecs[5] = '{x: -8'sd1,   exp: 1014};
        for (int i = 0; i < DEPTH + 2; i++) bd[i] = 8'(i * 13 - 60);

        // Reset state
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Single-sample vectors through the filter model
        for (int i = 0; i < 6; i++) run_single(vecs[i].x, vecs[i].exp, $sformatf("vec%0d", i));

        // Burst: fill the FIFO while the filter holds done low
        e1 = -8'sd1;
        e2 = 8'sd0;
        ff_log.delete();
        rv_log.delete();
        hold_low = 1'b1;
        tick();
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            s_data  = bd[i];
            s_valid = 1'b1;
            check($sformatf("burst s_ready %0d", i), s_ready, 1);
            tick();
        end
        s_data = bd[DEPTH];
        check("full s_ready", s_ready, 0);
        check("full fill", fill, DEPTH);
        check("no issue while done low", ff_log.size(), 0);
        hold_low = 1'b0;
        tick();
        check("full pop f_flag", f_flag, 1);
        check("full pop refuses push", fill, DEPTH - 1);
        check("full pop f_data", f_data, bd[0]);
        idx = DEPTH;
        k = 0;
        while (idx < DEPTH + 2 && k < 200) begin
            s_data  = bd[idx];
            s_valid = 1'b1;
            rdy     = s_ready;
            tick();
            if (rdy) idx++;
            k++;
        end
        s_valid = 1'b0;
        check("burst accepted all", idx, DEPTH + 2);
        k = 0;
        while (rv_log.size() < DEPTH + 2 && k < 400) begin
            tick();
            k++;
        end
        repeat (5) tick();
        check("burst r_valid pulses", rv_log.size(), DEPTH + 2);
        check("burst fill drained", fill, 0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            exp_v = 2 * bd[i] + 4 * e1 + 8 * e2;
            e2 = e1;
            e1 = bd[i];
            check($sformatf("burst order %0d", i), ff_log[i], bd[i]);
            check($sformatf("burst r_sum %0d", i), rv_log[i], exp_v);
        end

        // Stuck filter: done never drops
        stuck   = 1'b1;
        s_data  = 8'sd7;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        check("stuck issue", f_flag, 1);
        rv0 = rv_count;
        repeat (TIMEOUT) tick();
        check("timeout not early", timeout_err, 0);
        tick();
        check("timeout set", timeout_err, 1);
        repeat (3) tick();
        check("timeout no r_valid", rv_count - rv0, 0);
        stuck = 1'b0;
        exp_v = 2 * 25 + 4 * e1 + 8 * e2;
        run_single(8'sd25, exp_v, "after timeout");
        check("timeout sticky", timeout_err, 1);

        // Reset in WAIT_HIGH with three samples queued
        lat = 8;
        ff0 = ff_log.size();
        for (int i = 0; i < 4; i++) begin
            s_data  = 8'(10 + i);
            s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        check("queued before reset", fill, 3);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async reset");
        rv0 = rv_count;
        tick();
        tick();
        rst = 1'b0;
        lat = 2;
        repeat (30) tick();
        check("no r_valid after reset", rv_count - rv0, 0);
        check("no issue after reset", ff_log.size() - ff0, 1);
        check("fill after reset", fill, 0);
        check("f_data after reset", f_data, 0);

        run_single(8'sd5, 30, "post reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, actual running, required finished");
        $fatal(1);
    end

endmodule
